// File: rtl/oram_module.sv
// oram_module: single-client Path ORAM block store backed by on-chip tree, stash and position map
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset of control only
//   block_num     logical block address
//   write_val     write data
//   rw_indicator  1 = write, 0 = read
//   input_ready   request valid (level)
//   read_val      block contents before this access
//   output_ready  request complete, held until rst or input_ready drops
module oram_module #(
    parameter int TREE_DEPTH      = 4,
    parameter int BYTE_WIDTH      = 8,
    parameter int BYTES_PER_BLOCK = 4,
    parameter int BUCKET_SIZE     = 4,
    parameter int STASH_SIZE      = 24
) (
    input  logic [TREE_DEPTH-1:0]                 block_num,
    input  logic [BYTE_WIDTH*BYTES_PER_BLOCK-1:0] write_val,
    input  logic                                  rw_indicator,
    input  logic                                  input_ready,
    input  logic                                  clk,
    input  logic                                  rst,
    output logic [BYTE_WIDTH*BYTES_PER_BLOCK-1:0] read_val,
    output logic                                  output_ready
);
    localparam int DW  = BYTE_WIDTH * BYTES_PER_BLOCK;
    localparam int LW  = TREE_DEPTH - 1;
    localparam int NS  = ((1 << TREE_DEPTH) - 1) * BUCKET_SIZE;
    localparam int TW  = $clog2(NS);
    localparam int SW  = $clog2(STASH_SIZE);
    localparam int LVW = $clog2(TREE_DEPTH) > 0 ? $clog2(TREE_DEPTH) : 1;
    localparam int SLW = $clog2(BUCKET_SIZE) > 0 ? $clog2(BUCKET_SIZE) : 1;
    localparam logic [LVW-1:0] LAST_LVL  = LVW'(TREE_DEPTH - 1);
    localparam logic [SLW-1:0] LAST_SLOT = SLW'(BUCKET_SIZE - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOOKUP = 3'd1;
    localparam logic [2:0] READ   = 3'd2;
    localparam logic [2:0] ACCESS = 3'd3;
    localparam logic [2:0] EVICT  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]            state;
    logic [LVW-1:0]        lvl;
    logic [SLW-1:0]        slot;
    logic [TREE_DEPTH-1:0] req_blk;
    logic [DW-1:0]         req_wv;
    logic                  req_rw;
    logic [LW-1:0]         x, new_leaf;

    logic                  t_valid [NS];
    logic [TREE_DEPTH-1:0] t_id    [NS];
    logic [LW-1:0]         t_leaf  [NS];
    logic [DW-1:0]         t_data  [NS];
    logic                  s_valid [STASH_SIZE];
    logic [TREE_DEPTH-1:0] s_id    [STASH_SIZE];
    logic [LW-1:0]         s_leaf  [STASH_SIZE];
    logic [DW-1:0]         s_data  [STASH_SIZE];

    // Storage is never reset; registers power up as zero, so the position map is kept
    // XORed with the block's home leaf and the LFSR is kept inverted. That makes the
    // all-zero power-up state mean posmap[i] = i mod leaves and LFSR seed = all ones.
    logic [LW-1:0] posmap_x [1 << TREE_DEPTH];
    logic [15:0]   lfsr_n, lfsr, lfsr_next;
    logic [LW-1:0] pm_leaf;

    logic [TW-1:0] tidx;
    logic [SW-1:0] free_idx, hit_idx, ev_idx;
    logic          free_ok, hit_ok, ev_ok, last_slot;

    assign lfsr      = ~lfsr_n;
    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign pm_leaf   = posmap_x[req_blk] ^ LW'(req_blk);
    assign last_slot = slot == LAST_SLOT;

    always_comb begin
        tidx = TW'(((2 ** int'(lvl)) - 1 + int'(x >> (LW - int'(lvl)))) * BUCKET_SIZE + int'(slot));
        free_idx = '0;
        free_ok  = 1'b0;
        hit_idx  = '0;
        hit_ok   = 1'b0;
        ev_idx   = '0;
        ev_ok    = 1'b0;
        // scanning downward leaves the lowest qualifying index as the winner
        for (int i = STASH_SIZE - 1; i >= 0; i--) begin
            if (!s_valid[i]) begin
                free_idx = SW'(i);
                free_ok  = 1'b1;
            end
            if (s_valid[i] && s_id[i] == req_blk) begin
                hit_idx = SW'(i);
                hit_ok  = 1'b1;
            end
            if (s_valid[i] && (s_leaf[i] >> (LW - int'(lvl))) == (x >> (LW - int'(lvl)))) begin
                ev_idx = SW'(i);
                ev_ok  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        lfsr_n <= ~lfsr_next;
        if (state == IDLE && input_ready) begin
            req_blk <= block_num;
            req_wv  <= write_val;
            req_rw  <= rw_indicator;
        end
        if (state == LOOKUP) begin
            x        <= pm_leaf;
            new_leaf <= lfsr[LW-1:0];
        end
        if (state == READ && t_valid[tidx] && free_ok) begin
            s_valid[free_idx] <= 1'b1;
            s_id[free_idx]    <= t_id[tidx];
            s_leaf[free_idx]  <= t_leaf[tidx];
            s_data[free_idx]  <= t_data[tidx];
            t_valid[tidx]     <= 1'b0;
        end
        if (state == ACCESS) begin
            posmap_x[req_blk] <= new_leaf ^ LW'(req_blk);
            if (hit_ok) begin
                s_leaf[hit_idx] <= new_leaf;
                if (req_rw)
                    s_data[hit_idx] <= req_wv;
            end else if (req_rw && free_ok) begin
                s_valid[free_idx] <= 1'b1;
                s_id[free_idx]    <= req_blk;
                s_leaf[free_idx]  <= new_leaf;
                s_data[free_idx]  <= req_wv;
            end
        end
        if (state == EVICT) begin
            t_valid[tidx] <= ev_ok;
            if (ev_ok) begin
                t_id[tidx]        <= s_id[ev_idx];
                t_leaf[tidx]      <= s_leaf[ev_idx];
                t_data[tidx]      <= s_data[ev_idx];
                s_valid[ev_idx]   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            lvl          <= '0;
            slot         <= '0;
            read_val     <= '0;
            output_ready <= 1'b0;
        end else begin
            output_ready <= state == DONE;
            case (state)
                IDLE: begin
                    lvl  <= '0;
                    slot <= '0;
                    if (input_ready)
                        state <= LOOKUP;
                end
                LOOKUP: state <= READ;
                READ: begin
                    slot <= last_slot ? '0 : slot + 1'b1;
                    if (last_slot)
                        lvl <= lvl == LAST_LVL ? LAST_LVL : lvl + 1'b1;
                    if (last_slot && lvl == LAST_LVL)
                        state <= ACCESS;
                end
                ACCESS: begin
                    read_val <= hit_ok ? s_data[hit_idx] : '0;
                    state    <= EVICT;
                end
                EVICT: begin
                    slot <= last_slot ? '0 : slot + 1'b1;
                    if (last_slot && lvl != '0)
                        lvl <= lvl - 1'b1;
                    if (last_slot && lvl == '0)
                        state <= DONE;
                end
                DONE: if (!input_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_oram_module.sv
// tb_oram_module: scoreboard bench for oram_module against a flat block-memory model
module tb_oram_module;
    logic [3:0]  block_num;
    logic [31:0] write_val;
    logic        rw_indicator;
    logic        input_ready;
    logic        clk;
    logic        rst;
    logic [31:0] read_val;
    logic        output_ready;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [16];
    logic [31:0] exp_q [$];
    logic        prev_or = 1'b0;

    oram_module dut (
        .block_num(block_num), .write_val(write_val), .rw_indicator(rw_indicator),
        .input_ready(input_ready), .clk(clk), .rst(rst),
        .read_val(read_val), .output_ready(output_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (output_ready && !prev_or) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL read_val unexpected completion got %h", read_val);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (read_val !== e) begin
                    errors++;
                    $display("FAIL read_val got %h want %h", read_val, e);
                end
            end
        end
        prev_or = output_ready;
    end

    task automatic req(input logic [3:0] b, input logic [31:0] wv, input logic rw, input bit use_rst);
        int lat;
        @(negedge clk);
        block_num = b; write_val = wv; rw_indicator = rw; input_ready = 1'b1;
        exp_q.push_back(mem[b]);
        if (rw) mem[b] = wv;
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!output_ready && lat < 100);
        checks++;
        if (lat != 35) begin
            errors++;
            $display("FAIL latency got %0d want 35", lat);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (output_ready !== 1'b1) begin
                errors++;
                $display("FAIL hold output_ready got %b want 1", output_ready);
            end
        end
        if (use_rst) begin
            @(negedge clk);
            rst = 1'b1;
            input_ready = 1'b0;
            #1;
            checks++;
            if (output_ready !== 1'b0 || read_val !== '0) begin
                errors++;
                $display("FAIL in_reset got or=%b rv=%h want 0 0", output_ready, read_val);
            end
            @(negedge clk);
            rst = 1'b0;
        end else begin
            @(negedge clk);
            input_ready = 1'b0;
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (output_ready !== 1'b0) begin
                errors++;
                $display("FAIL release output_ready got %b want 0", output_ready);
            end
        end
    endtask

    task automatic abort_req(input logic [3:0] b, input logic [31:0] wv, input logic rw, input int k);
        @(negedge clk);
        block_num = b; write_val = wv; rw_indicator = rw; input_ready = 1'b1;
        @(posedge clk);
        repeat (k) @(posedge clk);
        #1;
        rst = 1'b1;
        input_ready = 1'b0;
        #1;
        checks++;
        if (output_ready !== 1'b0 || read_val !== '0) begin
            errors++;
            $display("FAIL abort_reset got or=%b rv=%h want 0 0", output_ready, read_val);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        block_num = '0; write_val = '0; rw_indicator = 1'b0; input_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (output_ready !== 1'b0 || read_val !== '0) begin
            errors++;
            $display("FAIL reset_state got or=%b rv=%h want 0 0", output_ready, read_val);
        end
        rst = 1'b0;
        req(4'd5, 32'd0, 1'b0, 1'b1);
        req(4'd1, 32'd2, 1'b1, 1'b1);
        req(4'd3, 32'd10, 1'b1, 1'b1);
        req(4'd1, 32'd0, 1'b0, 1'b1);
        req(4'd4, 32'd7, 1'b1, 1'b0);
        req(4'd4, 32'd9, 1'b1, 1'b0);
        req(4'd4, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) req(4'(i), 32'(i + 100), 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) req(4'(i), 32'd0, 1'b0, 1'(i % 2));
        req(4'd2, 32'd33, 1'b1, 1'b0);
        abort_req(4'd2, 32'd77, 1'b1, 5);
        req(4'd2, 32'd0, 1'b0, 1'b0);
        for (int n = 0; n < 40; n++)
            req(4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/oram_module.md
Name: oram_module

Overview:
- Single-client Path ORAM block store with 2^TREE_DEPTH logical blocks of BYTE_WIDTH*BYTES_PER_BLOCK bits each.
- Each request reads one root-to-leaf path of a bucket tree into a stash, services the access from the stash, remaps the block to a fresh random leaf, then evicts back along the same path.
- Sits between a request source using a level handshake and on-chip tree/stash/position-map storage.

Parameters:
- TREE_DEPTH, 4, levels in bucket tree; block_num width; 2^(TREE_DEPTH-1) leaves, 2^TREE_DEPTH-1 buckets.
- BYTE_WIDTH, 8, bits per byte.
- BYTES_PER_BLOCK, 4, bytes per data block.
- BUCKET_SIZE, 4, slots per bucket (Z).
- STASH_SIZE, 24, stash entries; must be >= TREE_DEPTH*BUCKET_SIZE+1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- block_num  in  TREE_DEPTH  logical block address.
- write_val  in  BYTE_WIDTH*BYTES_PER_BLOCK  write data.
- rw_indicator  in  1  1=write, 0=read.
- input_ready  in  1  request valid (level).
- read_val  out  BYTE_WIDTH*BYTES_PER_BLOCK  block contents before this access.
- output_ready  out  1  request complete.

Behaviour:
- Positional port order: block_num, write_val, rw_indicator, input_ready, clk, rst, read_val, output_ready.
- One clock; reset is asynchronous and active-high.
- rst resets only the FSM (to IDLE), read_val (0), output_ready (0) and the slot/level counters.
- Tree, stash, position map and LFSR are NOT affected by rst. Stored data survives any number of resets.
- Power-up initial values: all tree slots invalid; stash empty; posmap[i] = i mod 2^(TREE_DEPTH-1); LFSR seed nonzero (e.g. all ones); LFSR advances every cycle.
- Each tree slot and stash entry holds: valid, block id (TREE_DEPTH), leaf (TREE_DEPTH-1), data.
- Bucket at level l on path to leaf p: index (2^l - 1) + (p >> (TREE_DEPTH-1-l)).
- FSM:
  - IDLE: while input_ready=1, latch block_num, write_val, rw_indicator; go to LOOKUP.
  - LOOKUP (1 cycle): x = posmap[block]; new_leaf = LFSR low TREE_DEPTH-1 bits.
  - READ_PATH (TREE_DEPTH*BUCKET_SIZE cycles, one slot per cycle, level 0 first): each valid slot on path x moves to a free stash entry and is invalidated.
  - ACCESS (1 cycle):
    - Search stash for block. read_val = its data, or 0 if absent.
    - Write: store write_val, inserting a new entry if absent.
    - Read of an absent block: no entry created.
    - The stash entry leaf and posmap[block] are both set to new_leaf in this same cycle (atomic commit).
  - EVICT (TREE_DEPTH*BUCKET_SIZE cycles, leaf level first, one slot per cycle): write the lowest-index stash entry with (leaf >> (TREE_DEPTH-1-l)) == (x >> (TREE_DEPTH-1-l)) into the slot and remove it from the stash; if none qualifies, the slot stays invalid.
  - DONE: output_ready=1, read_val held. Stays in DONE until rst, or until input_ready=0 for one cycle (then IDLE). No new request is accepted while in DONE.
- Latency from request acceptance to output_ready: 2*TREE_DEPTH*BUCKET_SIZE+3 cycles (35 at defaults).
- Reset mid-operation: FSM returns to IDLE. Blocks already in the stash remain there and stay findable; the posmap is consistent because it is committed only in ACCESS. The aborted request is dropped.
- Stash full on insert: block is dropped. This cannot occur when STASH_SIZE satisfies its minimum.

Test Plan:
- Write 2 to block 1; after output_ready, pulse rst; write 10 to block 3; pulse rst; read block 1 -> read_val=2, output_ready=1.
- After power-up, read block 5 (never written) -> read_val=0.
- Write 7 to block 4, then write 9 to block 4 -> second write returns read_val=7; subsequent read -> 9.
- Write i+100 to every block 0..15 with rst between requests; read all -> each returns i+100.
- Assert rst during READ_PATH of a write to block 2 that previously held 33; re-issue the read -> 33, and output_ready=0 immediately on rst.
- Hold input_ready=1 -> output_ready exactly 35 cycles after acceptance and held until rst; read_val=0 and output_ready=0 while rst=1.
